pll_reconfig_seq: RTL and testbench
===================================

# pll_reconfig_seq

Parametrised PLL reconfiguration sequencer for speed modes: generalises the single native/60Hz overclock toggle to NUM_MODES fractional-divider presets. It filters a mode selection arriving from another clock domain and drives the Avalon-MM management port of the PLL reconfig IP with the mode/M-frac/start write sequence. It then waits for relock and reports status. It sits beside `pll_cfg`, on the management clock.

## Interface
- NUM_MODES, 4: number of speed presets, ≥2.
- STABLE_CYCLES, 4: consecutive identical synced samples required before a new mode is accepted.
- LOCK_DELAY, 64: cycles after the start write during which `pll_locked` is ignored.
- LOCK_TIMEOUT, 65536: maximum cycles to wait for lock after LOCK_DELAY.
- `clk` in 1: management clock (CLK_50M).
- `reset` in 1: synchronous, active-high.
- `mode_sel` in MW = $clog2(NUM_MODES): requested preset, asynchronous to `clk`.
- `frac_table` in NUM_MODES*32: preset i M-frac value at bits [32*i+31:32*i].
- `mgmt_waitrequest` in 1: reconfig IP stall.
- `pll_locked` in 1: PLL lock, asynchronous.
- `mgmt_write` out 1: write strobe.
- `mgmt_address` out 6: register address.
- `mgmt_writedata` out 32: write data.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse on successful relock.
- `lock_err` out 1: sticky; set on lock timeout.
- `cur_mode` out MW: last mode whose sequence was issued.

## Operation
- `mode_sel` and `pll_locked` pass through 2-FF synchronisers.
- Filter: a counter reloads whenever the synced `mode_sel` changes. The filtered mode updates after STABLE_CYCLES equal samples.
- States:
  - IDLE: if the filtered mode ≠ `cur_mode`, latch target, set `cur_mode` = target, go to WR_MODE.
  - WR_MODE: write address 0, data 0 (waitrequest mode). Then GAP, then WR_FRAC.
  - WR_FRAC: write address 7, data `frac_table[target]`. Then GAP, then WR_START.
  - WR_START: write address 2, data 0. Then DELAY.
  - DELAY: count LOCK_DELAY cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: on synced lock = 1, pulse `done`, clear `lock_err`, go to IDLE. If LOCK_TIMEOUT cycles elapse, set `lock_err` and go to IDLE.
- Write handshake: `mgmt_write`, `mgmt_address` and `mgmt_writedata` are held stable while `mgmt_write`=1. The write is accepted in the first cycle with `mgmt_waitrequest`=0. `mgmt_write` drops in the following cycle.
- GAP: exactly one cycle with `mgmt_write`=0 between writes.
- Mode changes during a sequence never abort it. The filter keeps tracking, and IDLE re-evaluates on re-entry. Only the latest filtered value is applied; intermediate values are dropped.
- An out-of-range `mode_sel` (≥ NUM_MODES) is clamped to NUM_MODES-1.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values:
  - `mgmt_write`, `mgmt_address`, `mgmt_writedata`, `busy`, `done`, `lock_err`: 0.
  - `cur_mode`: 0.
  - State: IDLE.
  - Filtered mode: 0. Mode 0 is the PLL power-on configuration.
- Latency:
  - `mode_sel` edge to accepted: 2 sync cycles + STABLE_CYCLES.
  - Accept to first `mgmt_write`=1: 1 cycle.
- Minimum sequence length with waitrequest always low: 3 writes + 2 gaps = 5 cycles, then LOCK_DELAY, then lock wait.
- `done` and `lock_err` are registered and change in the cycle after the condition.
- A reset mid-sequence returns immediately to the reset values. A write in flight is abandoned. If the synced mode ≠ 0 after reset, a full sequence reruns after filtering.
- Counter widths: $clog2 of the respective parameter + 1. There is no wrap; counters saturate at their terminal value.

## Structure
- `pll_reconfig_pkg` holds:
  - register address constants REG_MODE = 6'd0, REG_START = 6'd2, REG_MFRAC = 6'd7;
  - the state enum (IDLE, WR_MODE, GAP, WR_FRAC, WR_START, DELAY, WAIT_LOCK), with GAP carrying the return state;
  - the default M-frac constants 2748778984 (native) and 3221912667 (60Hz).
- Sub-module `sync_stable`, parametrised width W and STABLE_CYCLES: the 2-FF synchroniser plus stability filter. It is instantiated for `mode_sel` with W = MW, and for `pll_locked` with W = 1 and STABLE_CYCLES = 1.

## Test plan
- Reset, `mode_sel`=0 held for 1000 cycles → no `mgmt_write`, `busy`=0, `cur_mode`=0.
- `mode_sel` 0→1, waitrequest low, lock high after 100 cycles → writes (0,0), (7,3221912667), (2,0), each separated by 1 idle cycle. `done` pulses once and `cur_mode`=1.
- Waitrequest held high for 7 cycles during the WR_FRAC write → address and data stay stable for all 8 cycles. Exactly one accepted write.
- `mode_sel` glitches 0→2→0 within 3 cycles → no sequence. Then `mode_sel`=2 during WAIT_LOCK of a mode-1 sequence → mode-1 completes, then the mode-2 sequence runs.
- `pll_locked` held 0 → `lock_err` set after LOCK_DELAY + LOCK_TIMEOUT. The next successful sequence clears it.
- `reset` asserted mid WR_FRAC with `mode_sel`=3 → all outputs return to 0. After release, a full mode-3 sequence issues with data `frac_table[127:96]`.

Source files
------------

// File: rtl/pll_reconfig_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reconfig_pkg
//  Description : Shared constants and types for the PLL reconfiguration
//                sequencer: reconfig IP register map, sequencer states and
//                the default fractional-divider presets.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_reconfig_pkg;

    // Reconfig IP management register addresses
    localparam logic [5:0] REG_MODE  = 6'd0;
    localparam logic [5:0] REG_START = 6'd2;
    localparam logic [5:0] REG_MFRAC = 6'd7;

    // Default M-frac presets: native refresh and 60Hz overclock
    localparam logic [31:0] MFRAC_NATIVE = 32'd2748778984;
    localparam logic [31:0] MFRAC_60HZ   = 32'd3221912667;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_MODE   = 3'd1,
        GAP       = 3'd2,
        WR_FRAC   = 3'd3,
        WR_START  = 3'd4,
        DELAY     = 3'd5,
        WAIT_LOCK = 3'd6
    } seq_state_t;

    // GAP is a shared idle slot between writes; ret names where it resumes
    typedef struct packed {
        seq_state_t cur;
        seq_state_t ret;
    } seq_fsm_t;

endpackage
`default_nettype wire

// File: rtl/pll_reconfig_seq_sync_stable.sv
`default_nettype none
// ============================================================================
//  Module      : sync_stable
//  Description : Two-flop synchroniser followed by a stability filter. The
//                output only follows the synced input once it has been seen
//                unchanged for STABLE_CYCLES consecutive samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_stable
    import pll_reconfig_pkg::*;
#(
    parameter int W             = 1,
    parameter int STABLE_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int            CW       = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] c_stable = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] c_one    = CW'(1);

    logic [W-1:0]  r_meta;
    logic [W-1:0]  r_sync;
    logic [W-1:0]  r_prev;
    logic [W-1:0]  r_out;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    // Run length of the current synced value; a change restarts it at one
    // sample and it saturates once the value counts as stable
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_sync != r_prev) begin
            w_cnt_nxt = c_one;
        end else if (r_cnt < c_stable) begin
            w_cnt_nxt = r_cnt + c_one;
        end
    end

    // Synchroniser flops, run-length counter and filtered output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
            r_out  <= '0;
            r_cnt  <= '0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == c_stable) begin
                r_out <= r_sync;
            end
        end
    end

    assign dout = r_out;

endmodule
`default_nettype wire

// File: rtl/pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reconfig_seq
//  Description : Speed-mode PLL reconfiguration sequencer. Filters a mode
//                request from another clock domain, issues the mode / M-frac
//                / start write sequence on the reconfig IP management port,
//                then waits for relock and reports done or lock timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int   NUM_MODES     = 4,
    parameter int   STABLE_CYCLES = 4,
    parameter int   LOCK_DELAY    = 64,
    parameter int   LOCK_TIMEOUT  = 65536,
    localparam int  MW            = $clog2(NUM_MODES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MW-1:0]          mode_sel,
    input  logic [NUM_MODES*32-1:0] frac_table,
    input  logic                   mgmt_waitrequest,
    input  logic                   pll_locked,
    output logic                   mgmt_write,
    output logic [5:0]             mgmt_address,
    output logic [31:0]            mgmt_writedata,
    output logic                   busy,
    output logic                   done,
    output logic                   lock_err,
    output logic [MW-1:0]          cur_mode
);

    localparam int            DW          = $clog2(LOCK_DELAY) + 1;
    localparam int            TW          = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [DW-1:0] c_dly_last  = DW'(LOCK_DELAY - 1);
    localparam logic [TW-1:0] c_to_last   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [MW:0]   c_num_modes = (MW + 1)'(NUM_MODES);
    localparam logic [MW-1:0] c_mode_max  = MW'(NUM_MODES - 1);

    logic [MW-1:0] w_mode_filt;
    logic [MW-1:0] w_mode_req;
    logic          w_locked;
    logic [31:0]   w_frac;

    seq_fsm_t      r_fsm;
    seq_fsm_t      w_fsm_nxt;
    logic [MW-1:0] r_target;
    logic [MW-1:0] w_target_nxt;
    logic [MW-1:0] r_cur_mode;
    logic [MW-1:0] w_cur_nxt;
    logic [DW-1:0] r_dly_cnt;
    logic [DW-1:0] w_dly_nxt;
    logic [TW-1:0] r_to_cnt;
    logic [TW-1:0] w_to_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          r_lock_err;
    logic          w_err_nxt;

    sync_stable #(
        .W             (MW),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_mode_sync (
        .clk   (clk),
        .reset (reset),
        .din   (mode_sel),
        .dout  (w_mode_filt)
    );

    sync_stable #(
        .W             (1),
        .STABLE_CYCLES (1)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .din   (pll_locked),
        .dout  (w_locked)
    );

    // Requests beyond the preset table fall back to the last preset
    assign w_mode_req = ({1'b0, w_mode_filt} >= c_num_modes) ? c_mode_max : w_mode_filt;

    // M-frac word of the latched target preset
    always_comb begin
        w_frac = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (r_target == MW'(i)) begin
                w_frac = frac_table[32*i +: 32];
            end
        end
    end

    // Next-state logic and management-port drive, decoded from the
    // registered state so the write bus stays stable while stalled
    always_comb begin
        w_fsm_nxt      = r_fsm;
        w_target_nxt   = r_target;
        w_cur_nxt      = r_cur_mode;
        w_dly_nxt      = '0;
        w_to_nxt       = '0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = r_lock_err;
        mgmt_write     = 1'b0;
        mgmt_address   = REG_MODE;
        mgmt_writedata = '0;
        case (r_fsm.cur)
            IDLE: begin
                if (w_mode_req != r_cur_mode) begin
                    w_target_nxt  = w_mode_req;
                    w_cur_nxt     = w_mode_req;
                    w_fsm_nxt.cur = WR_MODE;
                end
            end
            WR_MODE: begin
                mgmt_write   = 1'b1;
                mgmt_address = REG_MODE;
                if (!mgmt_waitrequest) begin
                    w_fsm_nxt = '{cur: GAP, ret: WR_FRAC};
                end
            end
            GAP: begin
                w_fsm_nxt = '{cur: r_fsm.ret, ret: IDLE};
            end
            WR_FRAC: begin
                mgmt_write     = 1'b1;
                mgmt_address   = REG_MFRAC;
                mgmt_writedata = w_frac;
                if (!mgmt_waitrequest) begin
                    w_fsm_nxt = '{cur: GAP, ret: WR_START};
                end
            end
            WR_START: begin
                mgmt_write   = 1'b1;
                mgmt_address = REG_START;
                if (!mgmt_waitrequest) begin
                    w_fsm_nxt.cur = DELAY;
                end
            end
            DELAY: begin
                if (r_dly_cnt == c_dly_last) begin
                    w_fsm_nxt.cur = WAIT_LOCK;
                end else begin
                    w_dly_nxt = r_dly_cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (w_locked) begin
                    w_done_nxt    = 1'b1;
                    w_err_nxt     = 1'b0;
                    w_fsm_nxt.cur = IDLE;
                end else if (r_to_cnt == c_to_last) begin
                    w_err_nxt     = 1'b1;
                    w_fsm_nxt.cur = IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + 1'b1;
                end
            end
            default: begin
                w_fsm_nxt = '{cur: IDLE, ret: IDLE};
            end
        endcase
    end

    // State register, latched target and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm      <= '{cur: IDLE, ret: IDLE};
            r_target   <= '0;
            r_cur_mode <= '0;
            r_dly_cnt  <= '0;
            r_to_cnt   <= '0;
            r_done     <= 1'b0;
            r_lock_err <= 1'b0;
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_target   <= w_target_nxt;
            r_cur_mode <= w_cur_nxt;
            r_dly_cnt  <= w_dly_nxt;
            r_to_cnt   <= w_to_nxt;
            r_done     <= w_done_nxt;
            r_lock_err <= w_err_nxt;
        end
    end

    assign busy     = (r_fsm.cur != IDLE);
    assign done     = r_done;
    assign lock_err = r_lock_err;
    assign cur_mode = r_cur_mode;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_reconfig_seq
//  Description : Self-checking bench for pll_reconfig_seq. Expected write
//                lists, latencies and status come from the preset table and
//                the documented timing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reconfig_seq;
    import pll_reconfig_pkg::*;

    localparam int NUM_MODES     = 4;
    localparam int STABLE_CYCLES = 4;
    localparam int LOCK_DELAY    = 16;
    localparam int LOCK_TIMEOUT  = 200;
    localparam int MW            = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [MW-1:0]           mode_sel;
    logic [NUM_MODES*32-1:0] frac_table;
    logic                    mgmt_waitrequest;
    logic                    pll_locked;
    logic                    mgmt_write;
    logic [5:0]              mgmt_address;
    logic [31:0]             mgmt_writedata;
    logic                    busy;
    logic                    done;
    logic                    lock_err;
    logic [MW-1:0]           cur_mode;

    pll_reconfig_seq #(
        .NUM_MODES     (NUM_MODES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .LOCK_DELAY    (LOCK_DELAY),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mode_sel         (mode_sel),
        .frac_table       (frac_table),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked),
        .mgmt_write       (mgmt_write),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .busy             (busy),
        .done             (done),
        .lock_err         (lock_err),
        .cur_mode         (cur_mode)
    );

    always #10 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int unsigned fr [NUM_MODES];
    bit          rand_wait = 1'b0;
    int          done_pulses = 0;
    logic [37:0] acc_q [$];
    int          acc_cyc [$];

    // Bus monitor history (previous falling-edge sample)
    logic        h_wr = 1'b0, h_wait = 1'b0, h_acc1 = 1'b0, h_acc2 = 1'b0;
    logic [5:0]  h_addr = '0, h_acc1_addr = '0, h_acc2_addr = '0;
    logic [31:0] h_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference write for step k of a sequence targeting preset m
    function automatic logic [37:0] exp_wr(input int m, input int k);
        if (k == 0) return {REG_MODE, 32'h0};
        if (k == 1) return {REG_MFRAC, fr[m]};
        return {REG_START, 32'h0};
    endfunction

    // Bus protocol observation: stall stability, single gap, write order
    always @(negedge clk) begin
        if (reset) begin
            h_wr = 1'b0; h_wait = 1'b0; h_acc1 = 1'b0; h_acc2 = 1'b0;
        end else begin
            if (h_wr && h_wait) begin
                n_tests++;
                if (mgmt_write !== 1'b1 || mgmt_address !== h_addr || mgmt_writedata !== h_data) begin
                    n_fail++;
                    $display("FAIL hold_stable: got wr=%0b a=%0d d=%0h want wr=1 a=%0d d=%0h",
                             mgmt_write, mgmt_address, mgmt_writedata, h_addr, h_data);
                end
            end
            if (h_acc1) begin
                n_tests++;
                if (mgmt_write !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap_after_write: got wr=%0b want 0", mgmt_write);
                end
            end
            if (h_acc2 && h_acc2_addr != REG_START) begin
                n_tests++;
                if (mgmt_write !== 1'b1 ||
                    mgmt_address !== ((h_acc2_addr == REG_MODE) ? REG_MFRAC : REG_START)) begin
                    n_fail++;
                    $display("FAIL next_write: got wr=%0b a=%0d after a=%0d", mgmt_write, mgmt_address, h_acc2_addr);
                end
            end
            if (done === 1'b1) done_pulses++;
            h_acc2      = h_acc1;
            h_acc2_addr = h_acc1_addr;
            h_acc1      = mgmt_write && !mgmt_waitrequest;
            h_acc1_addr = mgmt_address;
            if (mgmt_write && !mgmt_waitrequest) begin
                acc_q.push_back({mgmt_address, mgmt_writedata});
                acc_cyc.push_back(cyc + 1);
            end
            h_wr   = mgmt_write;
            h_wait = mgmt_waitrequest;
            h_addr = mgmt_address;
            h_data = mgmt_writedata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_wait) mgmt_waitrequest = ($urandom_range(0, 3) == 0);
    endtask

    task automatic test_reset();
        bit seen_busy = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({mgmt_write, mgmt_address, mgmt_writedata, busy, done, lock_err, cur_mode} !== 44'h0) begin
            n_fail++;
            $display("FAIL reset_values: got wr=%0b a=%0d d=%0h busy=%0b done=%0b err=%0b cur=%0d want all 0",
                     mgmt_write, mgmt_address, mgmt_writedata, busy, done, lock_err, cur_mode);
        end
        reset = 1'b0;
        acc_q.delete(); acc_cyc.delete();
        repeat (1000) begin
            tick();
            if (busy === 1'b1 || mgmt_write === 1'b1) seen_busy = 1'b1;
        end
        n_tests++;
        if (seen_busy || acc_q.size() != 0 || cur_mode !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_mode0: got busy_seen=%0b writes=%0d cur=%0d want 0 0 0", seen_busy, acc_q.size(), cur_mode);
        end
    endtask

    task automatic test_glitch();
        bit seen_busy = 1'b0;
        mode_sel = 2'd2;
        tick(); tick();
        mode_sel = 2'd0;
        repeat (40) begin
            tick();
            if (busy === 1'b1) seen_busy = 1'b1;
        end
        n_tests++;
        if (seen_busy || acc_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_filter: got busy_seen=%0b writes=%0d want 0 0", seen_busy, acc_q.size());
        end
    endtask

    task automatic test_basic();
        int c0, first_wr = -1, done_cyc = -1;
        acc_q.delete(); acc_cyc.delete(); done_pulses = 0;
        c0 = cyc;
        mode_sel = 2'd1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (i == 99) pll_locked = 1'b1;
            if (first_wr < 0 && mgmt_write === 1'b1) first_wr = i + 1;
            if (done === 1'b1) begin done_cyc = cyc; break; end
        end
        n_tests++;
        if (first_wr != 2 + STABLE_CYCLES + 1) begin
            n_fail++;
            $display("FAIL accept_latency: got %0d edges want %0d", first_wr, 2 + STABLE_CYCLES + 1);
        end
        n_tests++;
        if (done_cyc != c0 + 104) begin
            n_fail++;
            $display("FAIL basic_done_time: got cyc %0d want %0d", done_cyc, c0 + 104);
        end
        repeat (3) tick();
        n_tests++;
        if (acc_q.size() != 3) begin
            n_fail++;
            $display("FAIL basic_write_count: got %0d want 3", acc_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (acc_q[k] !== exp_wr(1, k)) begin
                    n_fail++;
                    $display("FAIL basic_write%0d: got %0h want %0h", k, acc_q[k], exp_wr(1, k));
                end
            end
        end
        n_tests++;
        if (done_pulses != 1 || cur_mode !== 2'd1 || busy !== 1'b0 || lock_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_status: got pulses=%0d cur=%0d busy=%0b err=%0b want 1 1 0 0",
                     done_pulses, cur_mode, busy, lock_err);
        end
    endtask

    task automatic test_waitrequest();
        int stall = -1, done_cyc = -1, n_frac = 0;
        logic [5:0]  a0 = '0;
        logic [31:0] d0 = '0;
        acc_q.delete(); acc_cyc.delete(); done_pulses = 0;
        mode_sel = 2'd2;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (stall < 0 && mgmt_write === 1'b1 && mgmt_address === REG_MFRAC) begin
                stall = 0; a0 = mgmt_address; d0 = mgmt_writedata;
                mgmt_waitrequest = 1'b1;
            end else if (stall >= 0 && stall < 7) begin
                n_tests++;
                if (mgmt_write !== 1'b1 || mgmt_address !== a0 || mgmt_writedata !== d0) begin
                    n_fail++;
                    $display("FAIL stall_hold%0d: got wr=%0b a=%0d d=%0h want 1 %0d %0h",
                             stall, mgmt_write, mgmt_address, mgmt_writedata, a0, d0);
                end
                stall++;
                if (stall == 7) mgmt_waitrequest = 1'b0;
            end
            if (done === 1'b1) begin done_cyc = cyc; break; end
        end
        foreach (acc_q[k]) if (acc_q[k][37:32] == REG_MFRAC) n_frac++;
        n_tests++;
        if (n_frac != 1 || acc_q.size() != 3) begin
            n_fail++;
            $display("FAIL stall_accepts: got frac=%0d total=%0d want 1 3", n_frac, acc_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (acc_q[k] !== exp_wr(2, k)) begin
                    n_fail++;
                    $display("FAIL stall_write%0d: got %0h want %0h", k, acc_q[k], exp_wr(2, k));
                end
            end
            n_tests++;
            if (done_cyc != acc_cyc[2] + LOCK_DELAY + 1) begin
                n_fail++;
                $display("FAIL lock_delay_done: got cyc %0d want %0d", done_cyc, acc_cyc[2] + LOCK_DELAY + 1);
            end
        end
        n_tests++;
        if (cur_mode !== 2'd2) begin
            n_fail++;
            $display("FAIL stall_cur_mode: got %0d want 2", cur_mode);
        end
        tick();
    endtask

    task automatic test_no_abort();
        int guard = 0;
        acc_q.delete(); acc_cyc.delete(); done_pulses = 0;
        pll_locked = 1'b0;
        mode_sel = 2'd1;
        while (acc_q.size() < 3 && guard < 100) begin tick(); guard++; end
        repeat (LOCK_DELAY + 2) tick();
        mode_sel = 2'd3;
        repeat (10) tick();
        mode_sel = 2'd2;
        repeat (10) tick();
        n_tests++;
        if (busy !== 1'b1 || acc_q.size() != 3) begin
            n_fail++;
            $display("FAIL no_abort: got busy=%0b writes=%0d want 1 3", busy, acc_q.size());
        end
        pll_locked = 1'b1;
        guard = 0;
        while (done_pulses < 2 && guard < 400) begin tick(); guard++; end
        repeat (3) tick();
        n_tests++;
        if (acc_q.size() != 6 || done_pulses != 2) begin
            n_fail++;
            $display("FAIL queued_mode: got writes=%0d pulses=%0d want 6 2", acc_q.size(), done_pulses);
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_tests++;
                if (acc_q[k] !== exp_wr(k < 3 ? 1 : 2, k % 3)) begin
                    n_fail++;
                    $display("FAIL queued_write%0d: got %0h want %0h", k, acc_q[k], exp_wr(k < 3 ? 1 : 2, k % 3));
                end
            end
        end
        n_tests++;
        if (cur_mode !== 2'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL queued_status: got cur=%0d busy=%0b want 2 0", cur_mode, busy);
        end
    endtask

    task automatic test_lock_timeout();
        int err_cyc = -1, guard = 0;
        acc_q.delete(); acc_cyc.delete(); done_pulses = 0;
        pll_locked = 1'b0;
        mode_sel = 2'd0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (lock_err === 1'b1) begin err_cyc = cyc; break; end
        end
        n_tests++;
        if (acc_cyc.size() != 3 || err_cyc != acc_cyc[2] + LOCK_DELAY + LOCK_TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_time: got cyc %0d want %0d", err_cyc,
                     (acc_cyc.size() == 3) ? acc_cyc[2] + LOCK_DELAY + LOCK_TIMEOUT : -1);
        end
        repeat (20) tick();
        n_tests++;
        if (lock_err !== 1'b1 || busy !== 1'b0 || done_pulses != 0 || cur_mode !== 2'd0) begin
            n_fail++;
            $display("FAIL timeout_status: got err=%0b busy=%0b pulses=%0d cur=%0d want 1 0 0 0",
                     lock_err, busy, done_pulses, cur_mode);
        end
        pll_locked = 1'b1;
        mode_sel = 2'd1;
        while (done !== 1'b1 && guard < 300) begin tick(); guard++; end
        n_tests++;
        if (done !== 1'b1 || lock_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got done=%0b err=%0b want 1 0", done, lock_err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        mode_sel = 2'd3;
        while (!(mgmt_write === 1'b1 && mgmt_address === REG_MFRAC) && guard < 100) begin tick(); guard++; end
        mgmt_waitrequest = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if ({mgmt_write, mgmt_address, mgmt_writedata, busy, done, lock_err, cur_mode} !== 44'h0) begin
            n_fail++;
            $display("FAIL mid_reset_values: got wr=%0b a=%0d d=%0h busy=%0b cur=%0d want all 0",
                     mgmt_write, mgmt_address, mgmt_writedata, busy, cur_mode);
        end
        tick();
        acc_q.delete(); acc_cyc.delete(); done_pulses = 0;
        reset = 1'b0;
        mgmt_waitrequest = 1'b0;
        guard = 0;
        while (done !== 1'b1 && guard < 300) begin tick(); guard++; end
        tick();
        n_tests++;
        if (acc_q.size() != 3 || done_pulses != 1) begin
            n_fail++;
            $display("FAIL rerun_count: got writes=%0d pulses=%0d want 3 1", acc_q.size(), done_pulses);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (acc_q[k] !== exp_wr(3, k)) begin
                    n_fail++;
                    $display("FAIL rerun_write%0d: got %0h want %0h", k, acc_q[k], exp_wr(3, k));
                end
            end
        end
        n_tests++;
        if (cur_mode !== 2'd3) begin
            n_fail++;
            $display("FAIL rerun_cur_mode: got %0d want 3", cur_mode);
        end
    endtask

    task automatic test_random();
        int model_cur = 3;
        int m, lock_at;
        bit seen_busy;
        rand_wait = 1'b1;
        for (int n = 0; n < 8; n++) begin
            acc_q.delete(); acc_cyc.delete(); done_pulses = 0;
            m = $urandom_range(0, NUM_MODES - 1);
            lock_at = $urandom_range(20, 150);
            pll_locked = 1'b0;
            mode_sel = m[MW-1:0];
            if (m == model_cur) begin
                seen_busy = 1'b0;
                repeat (40) begin tick(); if (busy === 1'b1) seen_busy = 1'b1; end
                n_tests++;
                if (seen_busy || acc_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL rand_same%0d: got busy_seen=%0b writes=%0d want 0 0", n, seen_busy, acc_q.size());
                end
            end else begin
                for (int i = 0; i < 600; i++) begin
                    tick();
                    if (i == lock_at) pll_locked = 1'b1;
                    if (done === 1'b1) break;
                end
                repeat (3) tick();
                n_tests++;
                if (acc_q.size() != 3 || done_pulses != 1 || lock_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_seq%0d: got writes=%0d pulses=%0d err=%0b want 3 1 0",
                             n, acc_q.size(), done_pulses, lock_err);
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        n_tests++;
                        if (acc_q[k] !== exp_wr(m, k)) begin
                            n_fail++;
                            $display("FAIL rand_write%0d_%0d: got %0h want %0h", n, k, acc_q[k], exp_wr(m, k));
                        end
                    end
                end
                model_cur = m;
            end
            n_tests++;
            if (cur_mode !== model_cur[MW-1:0]) begin
                n_fail++;
                $display("FAIL rand_cur%0d: got %0d want %0d", n, cur_mode, model_cur);
            end
        end
        rand_wait = 1'b0;
        mgmt_waitrequest = 1'b0;
    endtask

    initial begin
        fr[0] = MFRAC_NATIVE;
        fr[1] = MFRAC_60HZ;
        fr[2] = $urandom;
        fr[3] = $urandom;
        frac_table       = {fr[3], fr[2], fr[1], fr[0]};
        reset            = 1'b1;
        mode_sel         = '0;
        mgmt_waitrequest = 1'b0;
        pll_locked       = 1'b0;
        test_reset();
        test_glitch();
        test_basic();
        test_waitrequest();
        test_no_abort();
        test_lock_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
